uart_rx_word_fifo: RTL and testbench

UART_RX_WORD_FIFO -- requirements
Module: uart_rx_word_fifo

---
 rtl/uart_rx_word_fifo.sv | 128 ++++++++++++
 tb/tb_uart_rx_word_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_fifo.sv
// UART byte-to-word packer (little-endian) feeding a first-word fall-through FIFO.
// Define UART_RX_TIMEOUT_EN to compile in the inter-byte timeout that discards stale partial words.
module uart_rx_word_fifo #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    uart_done,
    input  logic [7:0]              uart_data,
    input  logic                    rd_en,
    input  logic                    ovf_clr,
    output logic [31:0]             rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_word_fifo: DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_rx_word_fifo: TIMEOUT_CYCLES must be at least 1");
    end

    logic          r_done_d;
    logic [1:0]    r_idx;
    logic [23:0]   r_part;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          w_accept;
    logic          w_expire;
    logic          w_wr;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [31:0]   w_word;

    assign w_accept = uart_done & ~r_done_d;
    assign w_wr     = w_accept & (r_idx == 2'd3);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = rd_en & (r_count != '0);
    assign w_push   = w_wr & (~w_full | w_pop);
    assign w_drop   = w_wr & w_full & ~w_pop;
    assign w_word   = {uart_data, r_part};

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_tout;

    // An accepted byte wins over expiry in the same cycle.
    assign w_expire = (r_idx != 2'd0) & ~w_accept & (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tcnt <= '0;
            r_tout <= 1'b0;
        end else begin
            r_tout <= w_expire;
            if (w_accept || w_expire || r_idx == 2'd0)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);
        end
    end
    assign timeout = r_tout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // Load the live level so a pulse already high at release is not seen as a rise.
            r_done_d <= uart_done;
            r_idx    <= 2'd0;
            r_part   <= '0;
        end else begin
            r_done_d <= uart_done;
            if (w_accept) begin
                r_idx <= r_idx + 2'd1;
                case (r_idx)
                    2'd0:    r_part[7:0]   <= uart_data;
                    2'd1:    r_part[15:8]  <= uart_data;
                    2'd2:    r_part[23:16] <= uart_data;
                    default: ;
                endcase
            end else if (w_expire) begin
                r_idx <= 2'd0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr] <= w_word;
    end

    assign rd_data  = r_mem[r_rptr];
    assign rd_valid = (r_count != '0);
    assign count    = r_count;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Self-checking bench for uart_rx_word_fifo: vector table, corner sequences, random ops vs a queue model.
module tb_uart_rx_word_fifo;
    localparam int DEPTH = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_done = 1'b0;
    logic [7:0]  uart_data = 8'h00;
    logic        rd_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic        overflow;
    logic        timeout;

    uart_rx_word_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(50)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_done(uart_done), .uart_data(uart_data),
        .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .overflow(overflow), .timeout(timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int to_cnt = 0;
    always @(negedge sys_clk) if (timeout) to_cnt <= to_cnt + 1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: completed words, pending bytes, sticky overflow.
    logic [31:0] mq[$];
    logic [7:0]  mp[$];
    logic        mo = 1'b0;

    typedef struct {
        logic [3:0][7:0] b;
        int              hold;
        logic [31:0]     exp;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm);
        chk({nm, ".valid"}, 32'(rd_valid), 32'(mq.size() != 0));
        chk({nm, ".count"}, 32'(count), 32'(mq.size()));
        chk({nm, ".ovf"}, 32'(overflow), 32'(mo));
        if (mq.size() != 0) chk({nm, ".head"}, rd_data, mq[0]);
    endtask

    task automatic m_reset();
        mq.delete();
        mp.delete();
        mo = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b, input bit pop, input bit clr);
        logic [31:0] w;
        bit wr, popped, drop;
        wr = 0; drop = 0; w = '0;
        mp.push_back(b);
        if (mp.size() == 4) begin
            w = {mp[3], mp[2], mp[1], mp[0]};
            mp.delete();
            wr = 1;
        end
        popped = pop && mq.size() != 0;
        if (wr && mq.size() == DEPTH && !popped) drop = 1;
        if (popped) void'(mq.pop_front());
        if (wr && !drop) mq.push_back(w);
        if (drop) mo = 1'b1;
        else if (clr) mo = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        m_reset();
    endtask

    // rd_en / ovf_clr ride on the cycle of the uart_done rising edge.
    task automatic send(input logic [7:0] b, input int hold, input int gap, input bit pop, input bit clr);
        uart_data = b;
        uart_done = 1'b1;
        rd_en     = pop;
        ovf_clr   = clr;
        @(negedge sys_clk);
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        m_byte(b, pop, clr);
        repeat (hold - 1) @(negedge sys_clk);
        uart_done = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], 2, 1, 0, 0);
    endtask

    task automatic pop_op();
        rd_en = 1'b1;
        @(negedge sys_clk);
        rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic clr_op();
        ovf_clr = 1'b1;
        @(negedge sys_clk);
        ovf_clr = 1'b0;
        mo = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int since;
        int r;
        int hold;
        int gap;

        vecs[0] = '{b: {8'h44, 8'h33, 8'h22, 8'h11}, hold: 40, exp: 32'h44332211};
        vecs[1] = '{b: {8'hFF, 8'h00, 8'hFF, 8'h00}, hold: 1,  exp: 32'hFF00FF00};
        vecs[2] = '{b: {8'hEF, 8'hBE, 8'hAD, 8'hDE}, hold: 3,  exp: 32'hEFBEADDE};
        vecs[3] = '{b: {8'h04, 8'h03, 8'h02, 8'h01}, hold: 7,  exp: 32'h04030201};

        @(negedge sys_clk);
        do_reset();
        chk("rst.count", 32'(count), 0);
        chk("rst.valid", 32'(rd_valid), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.timeout", 32'(timeout), 0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) send(vecs[v].b[i], vecs[v].hold, 2, 0, 0);
            chk($sformatf("vec%0d.count", v), 32'(count), 1);
            chk($sformatf("vec%0d.valid", v), 32'(rd_valid), 1);
            chk($sformatf("vec%0d.data", v), rd_data, vecs[v].exp);
            pop_op();
            chk($sformatf("vec%0d.popcount", v), 32'(count), 0);
        end

        // Fill past capacity, then clear the sticky flag.
        do_reset();
        for (int w = 0; w <= DEPTH; w++)
            send_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        chk("ovf.count", 32'(count), 8);
        chk("ovf.flag", 32'(overflow), 1);
        chk("ovf.head", rd_data, 32'h03020100);
        check_state("ovf.model");
        clr_op();
        chk("ovf.cleared", 32'(overflow), 0);

        // Pop coinciding with the fourth-byte edge while full.
        send(8'hC0, 2, 1, 0, 0);
        send(8'hC1, 2, 1, 0, 0);
        send(8'hC2, 2, 1, 0, 0);
        send(8'hC3, 2, 1, 1, 0);
        chk("fullrw.count", 32'(count), 8);
        chk("fullrw.ovf", 32'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) begin
            check_state($sformatf("drain%0d", i));
            if (i == DEPTH - 1) chk("fullrw.tail", rd_data, 32'hC3C2C1C0);
            pop_op();
        end
        chk("drain.empty", 32'(count), 0);

        // Drop coinciding with ovf_clr keeps the flag set.
        for (int w = 0; w < DEPTH; w++) send_word(32'h5A000000 | 32'(w));
        send(8'h01, 2, 1, 0, 0);
        send(8'h02, 2, 1, 0, 0);
        send(8'h03, 2, 1, 0, 0);
        send(8'h04, 2, 1, 0, 1);
        chk("dropclr.ovf", 32'(overflow), 1);
        check_state("dropclr.model");

        // Inter-byte timeout.
        do_reset();
        t0 = to_cnt;
        send(8'h55, 2, 2, 0, 0);
        send(8'h66, 2, 60, 0, 0);
`ifdef UART_RX_TIMEOUT_EN
        chk("tmo.pulses", 32'(to_cnt - t0), 1);
        mp.delete();
`else
        chk("tmo.pulses", 32'(to_cnt - t0), 0);
`endif
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 3, 2, 0, 0);
`ifdef UART_RX_TIMEOUT_EN
        chk("tmo.word", rd_data, 32'hA3A2A1A0);
        chk("tmo.count", 32'(count), 1);
`endif
        check_state("tmo.model");

        // Reset mid-word with uart_done still high.
        do_reset();
        send(8'h01, 2, 2, 0, 0);
        send(8'h02, 2, 2, 0, 0);
        uart_data = 8'h03;
        uart_done = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        m_reset();
        repeat (5) @(negedge sys_clk);
        chk("rstmid.count", 32'(count), 0);
        chk("rstmid.valid", 32'(rd_valid), 0);
        uart_done = 1'b0;
        @(negedge sys_clk);
        send_word(32'h40302010);
        chk("rstmid.count1", 32'(count), 1);
        chk("rstmid.word", rd_data, 32'h40302010);

        // rd_en while empty.
        do_reset();
        rd_en = 1'b1;
        repeat (3) @(negedge sys_clk);
        rd_en = 1'b0;
        chk("emptyrd.count", 32'(count), 0);
        chk("emptyrd.valid", 32'(rd_valid), 0);
        send_word(32'h87654321);
        chk("emptyrd.word", rd_data, 32'h87654321);
        chk("emptyrd.count1", 32'(count), 1);

        // Random ops against the model; bytes are forced before any partial word can time out.
        do_reset();
        since = 0;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (mp.size() != 0 && since > 30) r = 0;
            if (r < 80) begin
                hold = $urandom_range(1, 4);
                gap  = $urandom_range(1, 4);
                send(8'($urandom), hold, gap, r >= 70, 0);
                since = hold + gap;
            end else if (r < 92) begin
                pop_op();
                since++;
            end else begin
                clr_op();
                since++;
            end
            check_state($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
